// File: rtl/ota_meas_pkg.sv
// Purpose : shared types and defaults for the OTA measurement sequencer and its readout mux.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ota_meas_pkg;

    // Default response-counter width and timeout limit (cycles).
    localparam int          CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;

    // Measurement sequence: settle low, time the rising step, settle high,
    // time the falling step.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRE_LO = 3'd1,
        RISE   = 3'd2,
        PRE_HI = 3'd3,
        FALL   = 3'd4
    } meas_state_t;

endpackage

// File: rtl/sync_ff.sv
// Purpose : N-stage flip-flop synchroniser for asynchronous pad inputs, reset value 0.
// Latency : STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports   : clk, rst (sync, active-high), d (async input), q (synchronised output).
module sync_ff #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/ota_step_timer.sv
// Purpose : drives a step onto the OTA input and times the comparator's rise/fall response in clk cycles.
// Latency : results valid on the done cycle; counts include the SYNC_STAGES synchroniser delay.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
// Ports   : clk, rst (sync, active-high), start (level), cmp_in (async comparator),
//           step_out (stimulus), busy, done (1-cycle pulse), timeout (sticky),
//           rise_cnt / fall_cnt (response times in cycles).
module ota_step_timer
    import ota_meas_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYC    = 64,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             step_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt
);

    localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    meas_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] stab_q, stab_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  rise_q, rise_d;
    logic [CNT_W-1:0]  fall_q, fall_d;
    logic              cmp_s;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .W      (1)
    ) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stab_q  <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            step_q  <= step_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // cnt doubles as the timeout timer and the response counter; it
        // saturates so a stuck comparator can never wrap it.
        cnt_d   = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
        stab_d  = stab_q;
        step_d  = step_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        rise_d  = rise_q;
        fall_d  = fall_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                stab_d = '0;
                step_d = 1'b0;
                if (start) begin
                    state_d = PRE_LO;
                    tmo_d   = 1'b0;
                    rise_d  = '0;
                    fall_d  = '0;
                end
            end
            PRE_LO: begin
                // Any high sample restarts the stability window; cnt keeps
                // running so a chattering comparator still times out.
                if (cmp_s) begin
                    stab_d = '0;
                end else if (stab_q == HOLD_LAST) begin
                    state_d = RISE;
                    step_d  = 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RISE: begin
                if (cmp_s) begin
                    rise_d  = cnt_q;
                    state_d = PRE_HI;
                end
            end
            PRE_HI: begin
                if (!cmp_s) begin
                    stab_d = '0;
                end else if (stab_q == HOLD_LAST) begin
                    state_d = FALL;
                    step_d  = 1'b0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            FALL: begin
                if (!cmp_s) begin
                    fall_d  = cnt_q;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 1'b0;
            end
        endcase

        // Timeout overrides whatever the state decided this cycle: abort to
        // IDLE with the stimulus released and the open count pinned at TMO.
        if ((state_q != IDLE) && (cnt_q == TMO)) begin
            state_d = IDLE;
            step_d  = 1'b0;
            done_d  = 1'b0;
            tmo_d   = 1'b1;
            if (state_q == RISE) begin
                rise_d = TMO;
            end
            if (state_q == FALL) begin
                fall_d = TMO;
            end
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end
    end

    assign step_out = step_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign timeout  = tmo_q;
    assign rise_cnt = rise_q;
    assign fall_cnt = fall_q;

endmodule
